ws2812b_vu_level: RTL and testbench

//  Upstream stage of ws2812b_meter_ioctrl. Turns a stream of signed audio samples into the bar length

---
 rtl/ws2812b_vu_pkg.sv | 23 ++
 rtl/ws2812b_seq_mul.sv | 51 +++++
 rtl/ws2812b_vu_level.sv | 133 +++++++++++++
 tb/tb_ws2812b_vu_level.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812b_vu_pkg.sv
// Shared widths, FSM state encoding and the sample magnitude helper for the VU level stage.
package ws2812b_vu_pkg;

  localparam int SAMPLE_W = 16;
  localparam int COUNT_W  = 16;
  localparam int PROD_W   = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    MUL  = ST_MUL,
    DONE = ST_DONE
  } vu_state_e;

  // Unsigned magnitude; -32768 maps to 32768 because the result is read as unsigned.
  function automatic logic [COUNT_W-1:0] abs_mag(input logic [SAMPLE_W-1:0] s);
    return s[SAMPLE_W-1] ? (~s + 16'd1) : s;
  endfunction

endpackage

// File: rtl/ws2812b_seq_mul.sv
// 16x16 unsigned shift-add multiplier: start loads operands, 16 busy cycles, one-cycle done pulse.
module ws2812b_seq_mul
  import ws2812b_vu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [COUNT_W-1:0]  a,
  input  logic [COUNT_W-1:0]  b,
  output logic                busy,
  output logic                done,
  output logic [PROD_W-1:0]   prod
);

  logic [PROD_W-1:0]  mcand;
  logic [COUNT_W-1:0] mplier;
  logic [PROD_W-1:0]  acc;
  logic [4:0]         cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        mcand  <= {{(PROD_W-COUNT_W){1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        cnt    <= 5'd16;
        busy   <= 1'b1;
      end else if (busy) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 5'd1;
        if (cnt == 5'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign prod = acc;

endmodule

// File: rtl/ws2812b_vu_level.sv
// Audio samples -> peak tracker -> per-frame bar length for the WS2812B meter.
// Optional peak-hold marker is built when WS2812B_VU_PEAK_HOLD_EN is defined.
module ws2812b_vu_level
  import ws2812b_vu_pkg::*;
#(
  parameter int FRAME_LEN   = 256,
  parameter int DECAY_DIV   = 16,
`ifdef WS2812B_VU_PEAK_HOLD_EN
  parameter int HOLD_FRAMES = 8,
`endif
  parameter int DECAY_SHIFT = 4
)
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic [COUNT_W-1:0]         maxCount,
  output logic [COUNT_W-1:0]         onCount,
  output logic                       level_valid,
`ifdef WS2812B_VU_PEAK_HOLD_EN
  output logic [COUNT_W-1:0]         peakCount,
`endif
  output logic [1:0]                 dbg_state
);

  vu_state_e          state, state_next;
  logic [COUNT_W-1:0] peak, peak_next, mag, step;
  logic [15:0]        frame_cnt, decay_cnt;
  logic [COUNT_W-1:0] snap, m_r, on_new;
  logic               decay_tick, frame_end, kick;
  logic               mul_busy, mul_done;
  logic [PROD_W-1:0]  mul_prod, scaled;

  always_comb begin
    mag        = abs_mag(sample);
    decay_tick = (decay_cnt == 16'(DECAY_DIV - 1));
    frame_end  = sample_valid && (frame_cnt == 16'(FRAME_LEN - 1));
    step       = peak >> DECAY_SHIFT;
    if (step == '0) step = 16'd1;
    peak_next  = peak;
    // Attack wins over a coincident decay tick.
    if (sample_valid) begin
      if (mag > peak)      peak_next = mag;
      else if (decay_tick) peak_next = (peak > step) ? (peak - step) : '0;
    end
  end

  // A frame end landing while busy only wraps the counter; the frame is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak      <= '0;
      frame_cnt <= '0;
      decay_cnt <= '0;
      snap      <= '0;
      m_r       <= '0;
      kick      <= 1'b0;
    end else begin
      peak <= peak_next;
      kick <= frame_end && (state == IDLE);
      if (sample_valid) begin
        decay_cnt <= decay_tick ? 16'd0 : decay_cnt + 16'd1;
        frame_cnt <= frame_end  ? 16'd0 : frame_cnt + 16'd1;
      end
      if (frame_end && (state == IDLE)) begin
        snap <= peak_next;
        m_r  <= maxCount;
      end
    end
  end

  ws2812b_seq_mul u_mul (
    .clk   (clk),
    .reset (reset),
    .start (kick && !mul_busy),
    .a     (snap),
    .b     (m_r),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_comb begin
    scaled = mul_prod >> 15;
    on_new = (scaled > {{(PROD_W-COUNT_W){1'b0}}, m_r}) ? m_r : scaled[COUNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_end) state_next = MUL;
      MUL:     if (mul_done)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Results land on the edge entering DONE, so they are valid for the whole pulse.
  always_ff @(posedge clk) begin
    if (reset)                         onCount <= '0;
    else if (state == MUL && mul_done) onCount <= on_new;
  end

  assign level_valid = (state == DONE);
  assign dbg_state   = state;

`ifdef WS2812B_VU_PEAK_HOLD_EN
  logic [15:0] hold_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      peakCount <= '0;
      hold_cnt  <= '0;
    end else if (state == MUL && mul_done) begin
      if (on_new >= peakCount) begin
        peakCount <= on_new;
        hold_cnt  <= 16'(HOLD_FRAMES);
      end else if (hold_cnt != 16'd0) begin
        hold_cnt  <= hold_cnt - 16'd1;
      end else begin
        // peakCount > on_new here, so one step down never undershoots the bar.
        peakCount <= peakCount - 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ws2812b_vu_level.sv
// Bench for ws2812b_vu_level: directed and random frames against a sample-level reference model.
module tb_ws2812b_vu_level;

  localparam int FRAME_LEN   = 256;
  localparam int DECAY_DIV   = 16;
  localparam int DECAY_SHIFT = 4;
  localparam int HOLD_FRAMES = 8;
  localparam int LATENCY     = 18;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               sample_valid = 1'b0;
  logic signed [15:0] sample = '0;
  logic [15:0]        maxCount = '0;
  logic [15:0]        onCount;
  logic               level_valid;
  logic [1:0]         dbg_state;
`ifdef WS2812B_VU_PEAK_HOLD_EN
  logic [15:0]        peakCount;
`endif

  int errors = 0;
  int checks = 0;
  int nc = 0;
  int pulses = 0;
  int exp_pulses = 0;
  bit silence = 1'b0;
  logic [15:0] last_on = '0;

  // reference model state
  int m_peak = 0;
  int m_dcnt = 0;
  int m_fcnt = 0;
  logic [15:0] exp_q[$];
  int          exp_at_q[$];
  int m_pk = 0;
  int m_hold = 0;

  ws2812b_vu_level dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample       (sample),
    .maxCount     (maxCount),
    .onCount      (onCount),
    .level_valid  (level_valid),
`ifdef WS2812B_VU_PEAK_HOLD_EN
    .peakCount    (peakCount),
`endif
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: every valid sample updates peak/decay/frame per the level rules.
  task automatic model_sample(input logic signed [15:0] s);
    int si, mag, step;
    longint p;
    bit tick;
    si  = s;
    mag = (si < 0) ? -si : si;
    m_dcnt++;
    tick = (m_dcnt == DECAY_DIV);
    if (tick) m_dcnt = 0;
    if (mag > m_peak) m_peak = mag;
    else if (tick) begin
      step = m_peak >> DECAY_SHIFT;
      if (step < 1) step = 1;
      m_peak = (m_peak > step) ? m_peak - step : 0;
    end
    m_fcnt++;
    if (m_fcnt == FRAME_LEN) begin
      m_fcnt = 0;
      p = (longint'(m_peak) * longint'(maxCount)) >>> 15;
      if (p > longint'(maxCount)) p = longint'(maxCount);
      exp_q.push_back(16'(p));
      exp_at_q.push_back(nc + LATENCY + 1);
      exp_pulses++;
    end
  endtask

  task automatic send(input logic signed [15:0] s);
    sample       = s;
    sample_valid = 1'b1;
    @(posedge clk);
    model_sample(s);
    #1 sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic signed [15:0] s);
    for (int i = 0; i < FRAME_LEN; i++) send(s);
  endtask

  task automatic wait_drain();
    int budget;
    budget = 3 * LATENCY;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    @(posedge clk);
    exp_q.delete();
    exp_at_q.delete();
    m_peak = 0; m_dcnt = 0; m_fcnt = 0; m_pk = 0; m_hold = 0;
    @(negedge clk);
    check("rst_on_count", onCount, 0);
    check("rst_level_valid", level_valid, 0);
    check("rst_state", dbg_state, 0);
`ifdef WS2812B_VU_PEAK_HOLD_EN
    check("rst_peak_count", peakCount, 0);
`endif
    reset = 1'b0;
  endtask

  // Monitor: every pulse must match the head of the expected queue in value and timing.
  always @(negedge clk) begin
    logic [15:0] e;
    int at;
    nc++;
    if (!reset && level_valid === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        e  = exp_q.pop_front();
        at = exp_at_q.pop_front();
        check("on_count", onCount, e);
        check("latency", nc, at);
        if (silence) check("non_increasing", (onCount > last_on), 0);
        last_on = onCount;
`ifdef WS2812B_VU_PEAK_HOLD_EN
        if (int'(e) >= m_pk) begin
          m_pk = e;
          m_hold = HOLD_FRAMES;
        end else if (m_hold > 0) m_hold--;
        else m_pk--;
        check("peak_count", peakCount, m_pk);
`endif
      end
    end
  end

  initial begin
    int aborted;
    // reset state
    repeat (3) @(posedge clk);
    do_reset();
    idle(2);

    // half-scale frame
    maxCount = 16'd50;
    send_frame(16'sd16384);
    wait_drain();

    // reset mid-multiply discards the frame
    send_frame(16'sd16384);
    idle(5);
    check("mid_mul_state", dbg_state, 1);
    aborted = exp_pulses;
    do_reset();
    exp_pulses = aborted - 1;
    idle(3 * LATENCY);

    // full-scale negative and positive
    send_frame(-16'sd32768);
    wait_drain();
    send_frame(16'sd32767);
    wait_drain();

    // full scale then silence decays to zero
    send_frame(-16'sd32768);
    wait_drain();
    silence = 1'b1;
    last_on = onCount;
    for (int f = 0; f < 6; f++) send_frame(16'sd0);
    wait_drain();
    check("silence_zero", onCount, 0);
    silence = 1'b0;

    // maxCount=0, then change mid-frame
    maxCount = 16'd0;
    send_frame(-16'sd32768);
    wait_drain();
    check("max_zero", onCount, 0);
    for (int i = 0; i < 100; i++) send(-16'sd32768);
    maxCount = 16'd10;
    for (int i = 0; i < FRAME_LEN - 100; i++) send(-16'sd32768);
    wait_drain();

    // random samples, gaps and strip lengths
    for (int f = 0; f < 3; f++) begin
      maxCount = 16'($urandom_range(0, 300));
      for (int i = 0; i < FRAME_LEN; i++) begin
        send(16'($urandom));
        idle($urandom_range(0, 2));
      end
      wait_drain();
    end

    // loud frame, long quiet run, loud again: exercises the hold marker
    maxCount = 16'd60;
    send_frame(16'sd32767);
    for (int f = 0; f < 14; f++) send_frame(16'sd3000);
    send_frame(-16'sd32768);
    wait_drain();

    idle(5);
    check("pulse_count", pulses, exp_pulses);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
